// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO family.
package sync_fifo_pkg;

  localparam int DEF_DEPTH = 16;
  localparam int DEF_WIDTH = 16;

  // Pointer/count width: address bits plus one wrap bit.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x WIDTH storage array with one write port and one registered read port.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // No reset here so the array and its output register map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/sync_fifo_thr.sv
// Synchronous FIFO with almost-full/empty thresholds, sticky overflow/underflow
// flags and a peak-occupancy watermark.
module sync_fifo_thr
  import sync_fifo_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          fifo_data_in,
  input  logic                      fifo_write,
  input  logic                      fifo_read,
  input  logic                      err_clr,
  output logic [WIDTH-1:0]          fifo_data_out,
  output logic                      fifo_full,
  output logic                      fifo_empty,
  output logic                      fifo_almost_full,
  output logic                      fifo_almost_empty,
  output logic [ptr_w(DEPTH)-1:0]   cnt,
  output logic [ptr_w(DEPTH)-1:0]   wr_ptr,
  output logic [ptr_w(DEPTH)-1:0]   rd_ptr,
  output logic                      overflow,
  output logic                      underflow,
  output logic [ptr_w(DEPTH)-1:0]   watermark
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_w(DEPTH);
  localparam logic [PW-1:0] ONE      = PW'(1);
  localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);
  localparam logic [PW-1:0] AF_CNT   = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_CNT   = PW'(AE_LEVEL);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sync_fifo_thr: DEPTH must be a power of 2 and at least 2");
  end
  if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_bad_af
    $error("sync_fifo_thr: AF_LEVEL must be in 1..DEPTH");
  end
  if ((AE_LEVEL < 0) || (AE_LEVEL > DEPTH - 1)) begin : g_bad_ae
    $error("sync_fifo_thr: AE_LEVEL must be in 0..DEPTH-1");
  end

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    watermark_q, watermark_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             dout_vld_q, dout_vld_d;
  logic             full, empty;
  logic             wr_acc, rd_acc;
  logic [WIDTH-1:0] mem_rd_data;

  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);

  always_comb begin
    wr_acc      = fifo_write && !full;
    rd_acc      = fifo_read && !empty;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    watermark_d = watermark_q;
    dout_vld_d  = dout_vld_q;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + ONE;
    end
    if (rd_acc) begin
      rd_ptr_d   = rd_ptr_q + ONE;
      dout_vld_d = 1'b1;
    end

    case ({wr_acc, rd_acc})
      2'b10:   cnt_d = cnt_q + ONE;
      2'b01:   cnt_d = cnt_q - ONE;
      default: cnt_d = cnt_q;
    endcase

    // A new error in the same cycle as err_clr takes priority over the clear.
    if (fifo_write && full) begin
      overflow_d = 1'b1;
    end else if (err_clr) begin
      overflow_d = 1'b0;
    end
    if (fifo_read && empty) begin
      underflow_d = 1'b1;
    end else if (err_clr) begin
      underflow_d = 1'b0;
    end

    if (err_clr || (cnt_d > watermark_q)) begin
      watermark_d = cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      watermark_q <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      dout_vld_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      watermark_q <= watermark_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      dout_vld_q  <= dout_vld_d;
    end
  end

  sync_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_q[AW-1:0]),
    .wr_data (fifo_data_in),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr_q[AW-1:0]),
    .rd_data (mem_rd_data)
  );

  // The RAM output register has no reset; masking it until the first read
  // since reset presents zero without touching the array.
  assign fifo_data_out     = dout_vld_q ? mem_rd_data : '0;
  assign fifo_full         = full;
  assign fifo_empty        = empty;
  assign fifo_almost_full  = (cnt_q >= AF_CNT);
  assign fifo_almost_empty = (cnt_q <= AE_CNT);
  assign cnt               = cnt_q;
  assign wr_ptr            = wr_ptr_q;
  assign rd_ptr            = rd_ptr_q;
  assign overflow          = overflow_q;
  assign underflow         = underflow_q;
  assign watermark         = watermark_q;

endmodule

// File: tb/tb_sync_fifo_thr.sv
// Directed scoreboard bench for sync_fifo_thr (DEPTH=16, WIDTH=16, AF=12, AE=4).
module tb_sync_fifo_thr;

  localparam int DEPTH = 16;
  localparam int WIDTH = 16;
  localparam int PW    = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] fifo_data_in = '0;
  logic             fifo_write = 1'b0;
  logic             fifo_read = 1'b0;
  logic             err_clr = 1'b0;
  logic [WIDTH-1:0] fifo_data_out;
  logic             fifo_full, fifo_empty, fifo_almost_full, fifo_almost_empty;
  logic [PW-1:0]    cnt, wr_ptr, rd_ptr, watermark;
  logic             overflow, underflow;

  sync_fifo_thr #(
    .DEPTH    (DEPTH),
    .WIDTH    (WIDTH),
    .AF_LEVEL (12),
    .AE_LEVEL (4)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .fifo_data_in      (fifo_data_in),
    .fifo_write        (fifo_write),
    .fifo_read         (fifo_read),
    .err_clr           (err_clr),
    .fifo_data_out     (fifo_data_out),
    .fifo_full         (fifo_full),
    .fifo_empty        (fifo_empty),
    .fifo_almost_full  (fifo_almost_full),
    .fifo_almost_empty (fifo_almost_empty),
    .cnt               (cnt),
    .wr_ptr            (wr_ptr),
    .rd_ptr            (rd_ptr),
    .overflow          (overflow),
    .underflow         (underflow),
    .watermark         (watermark)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] exp_q[$];
  int               m_cnt = 0;
  int               m_wm = 0;
  logic [PW-1:0]    m_wp = '0;
  logic [PW-1:0]    m_rp = '0;
  logic             m_ovf = 1'b0;
  logic             m_unf = 1'b0;
  logic [WIDTH-1:0] last_out = '0;
  logic             rd_expected = 1'b0;
  logic             rd_pending;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: data is due one cycle after each read the model says was accepted.
  always @(posedge clk or posedge rst) begin
    if (rst) rd_pending <= 1'b0;
    else     rd_pending <= rd_expected;
  end

  always @(negedge clk) begin
    if (rd_pending) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("[TB] FAIL rd_unexpected: got 0x%0h, expected no read data", fifo_data_out);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        $display("[TB] read data 0x%04h expected 0x%04h", fifo_data_out, e);
        chk("rd_data", 32'(fifo_data_out), 32'(e));
      end
    end
  end

  task automatic check_state();
    chk("cnt",       32'(cnt),               32'(m_cnt));
    chk("wr_ptr",    32'(wr_ptr),            32'(m_wp));
    chk("rd_ptr",    32'(rd_ptr),            32'(m_rp));
    chk("full",      32'(fifo_full),         32'(m_cnt == 16));
    chk("empty",     32'(fifo_empty),        32'(m_cnt == 0));
    chk("afull",     32'(fifo_almost_full),  32'(m_cnt >= 12));
    chk("aempty",    32'(fifo_almost_empty), 32'(m_cnt <= 4));
    chk("overflow",  32'(overflow),          32'(m_ovf));
    chk("underflow", 32'(underflow),         32'(m_unf));
    chk("watermark", 32'(watermark),         32'(m_wm));
    chk("data_out",  32'(fifo_data_out),     32'(last_out));
  endtask

  // Called at a falling edge: drive one cycle, advance the model, check at the next falling edge.
  task automatic step(input logic w, input logic r, input logic clr, input logic [WIDTH-1:0] d);
    logic full, empty, wa, ra;
    full  = (m_cnt == DEPTH);
    empty = (m_cnt == 0);
    wa    = w && !full;
    ra    = r && !empty;
    fifo_write   = w;
    fifo_read    = r;
    err_clr      = clr;
    fifo_data_in = d;
    rd_expected  = ra;
    if (ra) begin
      last_out = mq.pop_front();
      exp_q.push_back(last_out);
      m_rp = m_rp + 5'd1;
    end
    if (wa) begin
      mq.push_back(d);
      m_wp = m_wp + 5'd1;
    end
    m_cnt = m_cnt + (wa ? 1 : 0) - (ra ? 1 : 0);
    if (w && full) m_ovf = 1'b1;
    else if (clr)  m_ovf = 1'b0;
    if (r && empty) m_unf = 1'b1;
    else if (clr)   m_unf = 1'b0;
    if (clr || (m_cnt > m_wm)) m_wm = m_cnt;
    @(posedge clk);
    @(negedge clk);
    fifo_write  = 1'b0;
    fifo_read   = 1'b0;
    err_clr     = 1'b0;
    rd_expected = 1'b0;
    check_state();
  endtask

  // Asserts reset away from any edge and checks it takes effect without a clock.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    fifo_write = 1'b0;
    fifo_read = 1'b0;
    err_clr = 1'b0;
    rd_expected = 1'b0;
    mq.delete();
    exp_q.delete();
    m_cnt = 0;
    m_wm = 0;
    m_wp = '0;
    m_rp = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    last_out = '0;
    #1;
    $display("[TB] reset asserted");
    chk("rst_cnt",    32'(cnt), 0);
    chk("rst_empty",  32'(fifo_empty), 1);
    chk("rst_aempty", 32'(fifo_almost_empty), 1);
    check_state();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    do_reset();

    // Fill 0x0001..0x0010, then drain.
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 1'b0, 1'b0, 16'(i));
      $display("[TB] write 0x%04h cnt=%0d afull=%0b full=%0b", 16'(i), cnt, fifo_almost_full, fifo_full);
      if (i == 11) chk("afull_at_11", 32'(fifo_almost_full), 0);
      if (i == 12) chk("afull_at_12", 32'(fifo_almost_full), 1);
    end
    chk("full_at_16", 32'(fifo_full), 1);
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 1'b1, 1'b0, 16'h0000);
      if (i == 11) chk("aempty_at_5", 32'(fifo_almost_empty), 0);
      if (i == 12) chk("aempty_at_4", 32'(fifo_almost_empty), 1);
    end
    chk("drain_empty", 32'(fifo_empty), 1);
    chk("drain_wm", 32'(watermark), 16);

    // Overflow: write+read while full.
    for (int i = 1; i <= 16; i++) step(1'b1, 1'b0, 1'b0, 16'h0100 + 16'(i));
    step(1'b1, 1'b1, 1'b0, 16'hBEEF);
    $display("[TB] write+read at full: cnt=%0d overflow=%0b", cnt, overflow);
    chk("ovf_wr_ptr", 32'(wr_ptr), 0);
    chk("ovf_cnt", 32'(cnt), 15);
    chk("ovf_flag", 32'(overflow), 1);
    step(1'b0, 1'b0, 1'b1, 16'h0000);
    chk("clr_ovf", 32'(overflow), 0);
    chk("clr_wm", 32'(watermark), 15);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b0, 16'h0000);
    chk("ovf_drain_empty", 32'(fifo_empty), 1);

    // Underflow: read+write while empty.
    step(1'b1, 1'b1, 1'b0, 16'h00A5);
    $display("[TB] read+write at empty: cnt=%0d underflow=%0b", cnt, underflow);
    chk("unf_rd_ptr", 32'(rd_ptr), 0);
    chk("unf_cnt", 32'(cnt), 1);
    chk("unf_flag", 32'(underflow), 1);
    chk("unf_dout_hold", 32'(fifo_data_out), 32'h0110);
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    chk("unf_next_read", 32'(fifo_data_out), 32'h00A5);

    // Wrap-around with occupancy around 3.
    step(1'b0, 1'b0, 1'b1, 16'h0000);
    chk("clr_unf", 32'(underflow), 0);
    chk("clr_wm_zero", 32'(watermark), 0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 16'h2000 + 16'(i));
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b0, 1'b0, 16'h3000 + 16'(i));
      step(1'b0, 1'b1, 1'b0, 16'h0000);
    end
    chk("wrap_wm", 32'(watermark), 4);
    chk("wrap_cnt", 32'(cnt), 3);

    // err_clr colliding with an overflowing write.
    for (int i = 0; i < 13; i++) step(1'b1, 1'b0, 1'b0, 16'h4000 + 16'(i));
    chk("coll_full", 32'(fifo_full), 1);
    step(1'b1, 1'b0, 1'b1, 16'hDEAD);
    $display("[TB] err_clr with overflowing write: overflow=%0b", overflow);
    chk("coll_ovf", 32'(overflow), 1);

    // Reset mid-traffic, then confirm normal operation resumes.
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    step(1'b1, 1'b1, 1'b0, 16'h5555);
    do_reset();
    chk("post_rst_wp", 32'(wr_ptr), 0);
    chk("post_rst_wm", 32'(watermark), 0);
    step(1'b1, 1'b0, 1'b0, 16'h1234);
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    chk("post_rst_read", 32'(fifo_data_out), 32'h1234);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
